// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Expands one 512-bit message block into the SHA-256 schedule W0..W63 and
//   streams the words to the compression rounds, one word per handshake.
//   A 16-word sliding window holds W_t..W_t+15. Each accepted word shifts
//   the window and appends the next word computed with sigma0 and sigma1.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   blk_valid/blk_ready block handshake; blk_ready is a decode of IDLE
//   blk_data            M0 in [511:480] ... M15 in [31:0]
//   w_valid/w_ready     word handshake
//   w_data, w_index     schedule word W_t and its index t (registered)
//   w_last              high with the word where t = ROUNDS-1
//
// Only DATA_WIDTH = 32 is meaningful; the sigma rotate amounts are SHA-256's.
module sha256_msg_schedule #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    input  logic [16*DATA_WIDTH-1:0]   blk_data,
    output logic                       w_valid,
    input  logic                       w_ready,
    output logic [DATA_WIDTH-1:0]      w_data,
    output logic [5:0]                 w_index,
    output logic                       w_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] window [16];
    logic [DATA_WIDTH-1:0] next_w;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // window[0] is W_t, so the word entering at window[15] is W_t+16.
    assign next_w = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

    assign blk_ready = (state == IDLE);

    // w_index doubles as the round counter t.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_index <= '0;
            w_last  <= 1'b0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++)
                            window[i] <= blk_data[(15-i)*DATA_WIDTH +: DATA_WIDTH];
                        w_data  <= blk_data[15*DATA_WIDTH +: DATA_WIDTH];
                        w_index <= '0;
                        w_valid <= 1'b1;
                        w_last  <= (LAST_IDX == 6'd0);
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    // w_valid is always high in EMIT, so w_ready alone
                    // completes the handshake.
                    if (w_ready) begin
                        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                        window[15] <= next_w;
                        if (w_index == LAST_IDX) begin
                            state   <= IDLE;
                            w_valid <= 1'b0;
                            w_last  <= 1'b0;
                            w_index <= '0;
                        end else begin
                            w_data  <= window[1];
                            w_index <= w_index + 6'd1;
                            w_last  <= (w_index + 6'd1 == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    typedef logic [31:0] wvec_t [64];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    wvec_t got;

    sha256_msg_schedule #(.DATA_WIDTH(32), .ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_index(w_index), .w_last(w_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: straight FIPS 180-4 recurrence over a 64-entry array.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic wvec_t model(input logic [511:0] b);
        wvec_t w;
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " w_valid"}, {31'b0, w_valid}, 32'd0);
        check({tag, " w_data"}, w_data, 32'd0);
        check({tag, " w_index"}, {26'b0, w_index}, 32'd0);
        check({tag, " w_last"}, {31'b0, w_last}, 32'd0);
        check({tag, " blk_ready"}, {31'b0, blk_ready}, 32'd1);
    endtask

    // Offers blk (DUT must be idle), then consumes words.
    // mode 0: w_ready=1; mode 1: random ready with 20-cycle stalls at t=15,16,63;
    // mode 2: w_ready=1 plus a foreign block offered at t=30.
    // abort_at < 64 returns right after W(abort_at-1) is handshaken.
    task automatic run_block(input logic [511:0] blk, input int mode, input int abort_at,
                             input bit hold_valid, output int acc_cyc);
        wvec_t exp;
        int nexp, hs, budget, stall_left;
        bit rdy, offered;
        exp = model(blk);
        blk_data  = blk;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold_valid) blk_valid = 1'b0;
        nexp = 0; hs = 0; budget = 0; stall_left = 0; offered = 0;
        while (nexp < 64 && nexp != abort_at && budget < 1000) begin
            check("w_valid in EMIT", {31'b0, w_valid}, 32'd1);
            check("w_index", {26'b0, w_index}, nexp);
            check("w_data", w_data, exp[nexp]);
            check("w_last", {31'b0, w_last}, {31'b0, nexp == 63});
            check("blk_ready in EMIT", {31'b0, blk_ready}, 32'd0);
            got[nexp] = w_data;
            rdy = 1'b1;
            if (mode == 1) begin
                if ((nexp == 15 || nexp == 16 || nexp == 63) && stall_left == 0 && !rdy_done(nexp))
                    stall_left = 20;
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                    if (stall_left == 0) mark_done(nexp);
                end else begin
                    rdy = $urandom_range(0, 1) == 1;
                end
            end
            if (mode == 2) begin
                if (nexp == 30 && !offered) begin
                    blk_valid = 1'b1;
                    blk_data  = ~blk;
                    offered   = 1'b1;
                end else begin
                    blk_valid = hold_valid;
                    blk_data  = blk;
                end
            end
            w_ready = rdy;
            @(posedge clk); #1;
            if (rdy) begin nexp++; hs++; end
            budget++;
        end
        w_ready = 1'b0;
        if (abort_at >= 64) begin
            check("block completed in budget", hs, 64);
            check("w_valid after W63", {31'b0, w_valid}, 32'd0);
            check("w_last after W63", {31'b0, w_last}, 32'd0);
            check("blk_ready after W63", {31'b0, blk_ready}, 32'd1);
        end
    endtask

    // Tracks which stall points have already had their 20-cycle stall.
    bit stall_done [64];
    function automatic bit rdy_done(input int t);
        return stall_done[t];
    endfunction
    task automatic mark_done(input int t);
        stall_done[t] = 1'b1;
    endtask
    task automatic clear_stalls();
        for (int i = 0; i < 64; i++) stall_done[i] = 1'b0;
    endtask

    logic [511:0] abc_blk, ones_blk, rnd_blk, rnd2_blk;
    wvec_t        nostall;
    int           a1, a2, dummy;

    initial begin
        abc_blk  = {32'h61626380, 448'b0, 32'h00000018};
        ones_blk = {512{1'b1}};
        for (int i = 0; i < 16; i++) begin
            rnd_blk[32*i +: 32]  = $urandom;
            rnd2_blk[32*i +: 32] = $urandom;
        end
        clear_stalls();

        #2;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        // w_ready while idle must not matter
        w_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("idle w_ready");
        w_ready = 1'b0;

        // "abc" known answers
        run_block(abc_blk, 0, 64, 1'b0, dummy);
        check("abc W0", got[0], 32'h61626380);
        check("abc W15", got[15], 32'h00000018);
        check("abc W16", got[16], 32'h61626380);
        check("abc W17", got[17], 32'h000F0000);
        check("abc W18", got[18], 32'h7DA86405);
        check("abc W63", got[63], 32'h12B1EDEB);

        // all-ones: modular wrap
        run_block(ones_blk, 0, 64, 1'b0, dummy);
        check("ones W16", got[16], 32'h203FFFFC);

        // random block, no stall then with backpressure
        run_block(rnd_blk, 0, 64, 1'b0, dummy);
        nostall = got;
        run_block(rnd_blk, 1, 64, 1'b0, dummy);
        for (int i = 0; i < 64; i += 9) check("stall vs no-stall", got[i], nostall[i]);
        check("stall vs no-stall W63", got[63], nostall[63]);

        // back-to-back with blk_valid held high
        run_block(rnd_blk, 0, 64, 1'b1, a1);
        run_block(rnd2_blk, 0, 64, 1'b0, a2);
        check("block period", a2 - a1, 65);

        // block offered while busy is ignored
        run_block(abc_blk, 2, 64, 1'b0, dummy);
        blk_valid = 1'b0;

        // asynchronous reset after W20 handshaken
        run_block(rnd2_blk, 0, 21, 1'b0, dummy);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-block reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after reset release");
        run_block(rnd2_blk, 0, 64, 1'b0, dummy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
